dep_vector_gen: RTL

DEP_VECTOR_GEN -- requirements
Module: dep_vector_gen

---
 rtl/dep_vector_gen.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/dep_vector_gen.sv
// Builds one dependency-table row per allocated instruction and rewrites
// the whole table, one row per cycle, after each retire.
module dep_vector_gen #(
  parameter int bs = 16,
  parameter int rw = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [rw-1:0]          in_rd,
  input  logic [rw-1:0]          in_rs1,
  input  logic [rw-1:0]          in_rs2,
  input  logic                   in_rd_we,
  input  logic                   retire_valid,
  input  logic [$clog2(bs)-1:0]  retire_index,
  output logic                   retire_ready,
  output logic [$clog2(bs)-1:0]  buffer_index,
  output logic [bs-1:0]          current_idt,
  output logic                   idt_we,
  output logic [$clog2(bs):0]    occupancy,
  output logic                   full
);

  localparam int iw = $clog2(bs);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t state, state_nx;

  logic [bs-1:0] vld;
  logic [bs-1:0] wr;
  logic [rw-1:0] rd_q  [bs];
  logic [rw-1:0] rs1_q [bs];
  logic [rw-1:0] rs2_q [bs];
  logic [bs-1:0] dep   [bs];
  logic [bs-1:0] dep_clr [bs];

  logic [iw-1:0] ptr;
  logic [iw-1:0] free_idx;
  logic [bs-1:0] new_row;
  logic          alloc;
  logic          ret;
  logic          ret_hit;

  assign full         = occupancy == (iw+1)'(bs);
  assign retire_ready = state == IDLE;
  assign in_ready     = (state == IDLE) && !full && !retire_valid;
  assign alloc        = in_valid && in_ready;
  assign ret          = retire_valid && retire_ready;
  assign ret_hit      = ret && vld[retire_index];

  always_comb begin
    free_idx = '0;
    for (int j = bs - 1; j >= 0; j--)
      if (!vld[j]) free_idx = iw'(j);
  end

  // x0 never carries a dependency, so every match is qualified on nonzero.
  always_comb begin
    new_row = '0;
    for (int j = 0; j < bs; j++) begin
      new_row[j] = vld[j] && (
        (wr[j] && rd_q[j] != '0 &&
          (rd_q[j] == in_rs1 || rd_q[j] == in_rs2)) ||
        (wr[j] && in_rd_we && in_rd != '0 && rd_q[j] == in_rd) ||
        (in_rd_we && in_rd != '0 &&
          (in_rd == rs1_q[j] || in_rd == rs2_q[j])));
    end
  end

  // Empty rows stay all ones; only live rows lose the retired column.
  always_comb begin
    for (int k = 0; k < bs; k++) begin
      dep_clr[k] = dep[k];
      if (k == int'(retire_index))
        dep_clr[k] = '1;
      else if (vld[k])
        dep_clr[k][retire_index] = 1'b0;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (ret_hit) state_nx = SWEEP;
      SWEEP:   if (ptr == iw'(bs - 1)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld          <= '0;
      wr           <= '0;
      ptr          <= '0;
      idt_we       <= 1'b0;
      buffer_index <= '0;
      current_idt  <= '1;
      occupancy    <= '0;
      for (int k = 0; k < bs; k++) begin
        dep[k]   <= '1;
        rd_q[k]  <= '0;
        rs1_q[k] <= '0;
        rs2_q[k] <= '0;
      end
    end else begin
      idt_we <= 1'b0;
      if (alloc) begin
        vld[free_idx]   <= 1'b1;
        wr[free_idx]    <= in_rd_we;
        rd_q[free_idx]  <= in_rd;
        rs1_q[free_idx] <= in_rs1;
        rs2_q[free_idx] <= in_rs2;
        dep[free_idx]   <= new_row;
        buffer_index    <= free_idx;
        current_idt     <= new_row;
        idt_we          <= 1'b1;
        occupancy       <= occupancy + 1'b1;
      end else if (ret_hit) begin
        vld[retire_index] <= 1'b0;
        for (int k = 0; k < bs; k++)
          dep[k] <= dep_clr[k];
        buffer_index <= '0;
        current_idt  <= dep_clr[0];
        idt_we       <= 1'b1;
        ptr          <= iw'(1);
        occupancy    <= occupancy - 1'b1;
      end else if (state == SWEEP) begin
        buffer_index <= ptr;
        current_idt  <= dep[ptr];
        idt_we       <= 1'b1;
        ptr          <= ptr + 1'b1;
      end
    end
  end

endmodule
